// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control/status bundle between software-facing logic and
// the interval timer.
//   master : drives configuration and control, observes timer status
//   slave  : the timer itself
// Signals:
//   cfg_we, cfg_limit[N-1:0], cfg_periodic : configuration write (IDLE only)
//   start, stop, pause, irq_clr             : per-cycle control levels
//   count[N-1:0], done, busy, irq           : timer status
interface timer_ctrl_if #(
  parameter int unsigned N = 4
);
  logic         cfg_we;
  logic [N-1:0] cfg_limit;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         pause;
  logic         irq_clr;
  logic [N-1:0] count;
  logic         done;
  logic         busy;
  logic         irq;

  modport master (
    output cfg_we, cfg_limit, cfg_periodic, start, stop, pause, irq_clr,
    input  count, done, busy, irq
  );

  modport slave (
    input  cfg_we, cfg_limit, cfg_periodic, start, stop, pause, irq_clr,
    output count, done, busy, irq
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer controller around an N-bit
// up-counter. Start/stop/pause control, one-shot or periodic reload,
// one-cycle terminal-count pulse (done) and sticky interrupt flag (irq).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : timer_ctrl_if.slave (config, control, count/done/busy/irq)
// Parameters:
//   N   : count width
//   DIV : tick divider ratio (>=1), only used with TIMER_PRESCALE_EN
// Build option:
//   TIMER_PRESCALE_EN : when defined, an internal prescaler issues one
//   count tick every DIV cycles in RUN; otherwise every RUN cycle ticks.
module timer_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  if (DIV == 0) begin : g_div_check
    $error("timer_ctrl: DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] limit_q, limit_d;
  logic         per_q, per_d;
  logic         done_q, done_d;
  logic         irq_q, irq_d;

  // A counting cycle: timer active, not aborted, not held.
  logic advance;
  logic tick;

  assign advance = (state_q != IDLE) && !bus.stop && !bus.pause;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PW'(DIV - 1));
  assign tick     = advance && pre_wrap;

  // Held at zero in IDLE so every run starts with a full prescale period;
  // frozen whenever advance is low (HOLD / pause).
  always_comb begin
    pre_d = pre_q;
    if (state_q == IDLE || bus.stop) begin
      pre_d = '0;
    end else if (advance) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = advance;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    per_d   = per_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.cfg_we) begin
          limit_d = bus.cfg_limit;
          per_d   = bus.cfg_periodic;
        end
        if (bus.start && !bus.stop) begin
          state_d = RUN;
        end
      end

      RUN, HOLD: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.pause) begin
          state_d = HOLD;
        end else begin
          // Leaving HOLD counts on the same edge, so the count is frozen
          // for exactly the cycles pause was high.
          state_d = RUN;
          if (tick) begin
            if (count_q == limit_q) begin
              count_d = '0;
              done_d  = 1'b1;
              if (!per_q) begin
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Set has priority over a coincident clear.
  always_comb begin
    irq_d = irq_q;
    if (bus.irq_clr) begin
      irq_d = 1'b0;
    end
    if (done_d) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '1;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      per_q   <= per_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.count = count_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl. Directed vector table,
// hand-written multi-cycle sequences, and randomized control compared with
// a tick-counting reference model.
module tb_timer_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
`ifdef TIMER_PRESCALE_EN
  localparam int DIVM = DIV;
`else
  localparam int DIVM = 1;
`endif

  logic clk;
  logic reset;

  timer_ctrl_if #(.N(N)) bus ();

  timer_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passed;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference model: tracks how many ticks have elapsed since the run
  // started; count and done follow from that total by modular arithmetic.
  int m_active;
  int m_limit;
  int m_per;
  int m_irq;
  int m_done;
  int m_ticks;
  int m_sub;

  task automatic model_reset();
    m_active = 0;
    m_limit  = (1 << N) - 1;
    m_per    = 0;
    m_irq    = 0;
    m_done   = 0;
    m_ticks  = 0;
    m_sub    = 0;
  endtask

  function automatic int m_count();
    return (m_active != 0) ? (m_ticks % (m_limit + 1)) : 0;
  endfunction

  task automatic model_update();
    m_done = 0;
    if (m_active == 0) begin
      if (bus.cfg_we) begin
        m_limit = int'(bus.cfg_limit);
        m_per   = int'(bus.cfg_periodic);
      end
      if (bus.start && !bus.stop) begin
        m_active = 1;
        m_ticks  = 0;
        m_sub    = 0;
      end
    end else if (bus.stop) begin
      m_active = 0;
      m_ticks  = 0;
      m_sub    = 0;
    end else if (!bus.pause) begin
      m_sub++;
      if (m_sub == DIVM) begin
        m_sub = 0;
        m_ticks++;
        if (m_ticks % (m_limit + 1) == 0) begin
          m_done = 1;
          if (m_per == 0) m_active = 0;
        end
      end
    end
    if (m_done != 0)     m_irq = 1;
    else if (bus.irq_clr) m_irq = 0;
  endtask

  task automatic set_in(input logic we, input logic [N-1:0] lim, input logic per,
                        input logic st, input logic sp, input logic pa,
                        input logic clr);
    bus.cfg_we       = we;
    bus.cfg_limit    = lim;
    bus.cfg_periodic = per;
    bus.start        = st;
    bus.stop         = sp;
    bus.pause        = pa;
    bus.irq_clr      = clr;
  endtask

  task automatic idle_in();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, int'(bus.count), m_count());
    chk({tag, "_done"},  int'(bus.done),  m_done);
    chk({tag, "_busy"},  int'(bus.busy),  m_active);
    chk({tag, "_irq"},   int'(bus.irq),   m_irq);
  endtask

  typedef struct {
    logic         we;
    logic [N-1:0] lim;
    logic         per;
    logic         st;
    logic         sp;
    logic         pa;
    logic         clr;
    logic [N-1:0] ecount;
    logic         edone;
    logic         ebusy;
    logic         eirq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic [N-1:0] lim, input logic per,
                     input logic st, input logic sp, input logic pa, input logic clr,
                     input logic [N-1:0] ec, input logic ed, input logic eb,
                     input logic ei);
    vec_t v;
    v.we = we; v.lim = lim; v.per = per; v.st = st; v.sp = sp; v.pa = pa;
    v.clr = clr; v.ecount = ec; v.edone = ed; v.ebusy = eb; v.eirq = ei;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    checks = 0;
    passed = 0;

    //      we lim per st sp pa clr | cnt done busy irq
    // one-shot, limit=3 (irq_clr also clears the flag left by the prior run)
    add(1, 3, 0, 1, 0, 0, 1,   0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    // start+stop together stays IDLE; then periodic limit=5 with pause,
    // ignored cfg_we/start while running, irq_clr coincident with done
    add(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 0, 0,   0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0,   3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   5, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
    // limit=0 periodic then one-shot
    add(1, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);

    // Reset for two cycles
    reset = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_done",  int'(bus.done),  0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_irq",   int'(bus.irq),   0);
    reset = 1'b1;

    // Start without configuration: default limit 15
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("dflt_start_busy",  int'(bus.busy),  1);
    chk("dflt_start_count", int'(bus.count), 0);
    idle_in();
    for (int i = 1; i <= 16 * DIVM; i++) begin
      step();
      if (i < 16 * DIVM) begin
        chk("dflt_count", int'(bus.count), i / DIVM);
        chk("dflt_done",  int'(bus.done),  0);
      end else begin
        chk("dflt_end_count", int'(bus.count), 0);
        chk("dflt_end_done",  int'(bus.done),  1);
        chk("dflt_end_busy",  int'(bus.busy),  0);
        chk("dflt_end_irq",   int'(bus.irq),   1);
      end
    end

`ifndef TIMER_PRESCALE_EN
    foreach (tbl[k]) begin
      set_in(tbl[k].we, tbl[k].lim, tbl[k].per, tbl[k].st, tbl[k].sp,
             tbl[k].pa, tbl[k].clr);
      step();
      chk($sformatf("tbl%0d_count", k), int'(bus.count), int'(tbl[k].ecount));
      chk($sformatf("tbl%0d_done", k),  int'(bus.done),  int'(tbl[k].edone));
      chk($sformatf("tbl%0d_busy", k),  int'(bus.busy),  int'(tbl[k].ebusy));
      chk($sformatf("tbl%0d_irq", k),   int'(bus.irq),   int'(tbl[k].eirq));
    end
`else
    // limit=1 one-shot, DIV=4: done on the 8th edge after the start edge
    set_in(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("ps_done_e%0d", i), int'(bus.done), (i == 8) ? 1 : 0);
    end
    // Two paused cycles mid-prescale push done out by exactly two edges
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, (i == 3 || i == 4), 1'b0);
      step();
      chk($sformatf("ps_pause_done_e%0d", i), int'(bus.done), (i == 10) ? 1 : 0);
    end
    idle_in();
`endif

    // Randomized control against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] lim;
      lim = ($urandom_range(0, 9) == 0) ? N'($urandom) : N'($urandom_range(0, 4));
      set_in(($urandom_range(0, 4) == 0), lim, 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
      step();
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in mid-run at count=2
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    repeat (2 * DIVM) step();
    chk("arst_pre_count", int'(bus.count), 2);
    chk("arst_pre_busy",  int'(bus.busy),  1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_count", int'(bus.count), 0);
    chk("arst_busy",  int'(bus.busy),  0);
    chk("arst_done",  int'(bus.done),  0);
    chk("arst_irq",   int'(bus.irq),   0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
    repeat (20 * DIVM) begin
      step();
      check_model("post_arst");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
